// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: FSM state encoding
// and the address-width helper.
package regfile_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Address width needed to index a power-of-two register count
  function automatic int unsigned aw_of(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: register select, x0 zeroing and
// same-cycle write bypass.
module regfile_rdport #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic            run,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] mem [DEPTH],
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  // Reads are zero while initialising and for register 0
  always_comb begin
    rdata = '0;
    if (run && (raddr != '0)) begin
      if (we && (waddr == raddr)) begin
        rdata = wdata;
      end else begin
        rdata = mem[raddr];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with self-clearing INIT sequence after reset.
// Optional busy scoreboard enabled by defining REGFILE_MP_SCOREBOARD_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned RD_PORTS = 2,
  localparam int unsigned AW      = aw_of(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef REGFILE_MP_SCOREBOARD_EN
  input  logic                     sb_set,
  input  logic [AW-1:0]            sb_addr,
  output logic [RD_PORTS-1:0]      busy,
`endif
  input  logic [RD_PORTS*AW-1:0]   raddr,
  output logic [RD_PORTS*XLEN-1:0] rdata,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [XLEN-1:0]          wdata,
  output logic                     ready
);

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            ready_q, ready_d;
  logic            run;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_q [DEPTH];

  // INIT walks clr_cnt over the array writing zeros; RUN takes user writes
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end
      end
      default: begin
        mem_we = we && (waddr != '0);
      end
    endcase
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Array has no reset; contents are defined only by the INIT sweep
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign run   = (state_q == ST_RUN);
  assign ready = ready_q;

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    regfile_rdport #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_rdport (
      .run   (run),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .mem   (mem_q),
      .raddr (raddr[i*AW +: AW]),
      .rdata (rdata[i*XLEN +: XLEN])
    );
  end

`ifdef REGFILE_MP_SCOREBOARD_EN
  logic [DEPTH-1:0] busy_q, busy_d;

  // A write clears its register's busy bit; a same-cycle set takes priority
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (we && (waddr != '0)) begin
        busy_d[waddr] = 1'b0;
      end
      if (sb_set && (sb_addr != '0)) begin
        busy_d[sb_addr] = 1'b1;
      end
    end else begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_busy
    assign busy[i] = busy_q[raddr[i*AW +: AW]];
  end
`endif

endmodule
